// File: rtl/alu_regfile.sv
// Operand register file (r0 hard-wired to zero, write-through bypass) and
// carry/zero flag register sitting upstream of the 8-bit ALU.
module alu_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_ra_addr,
  input  logic [ADDR_W-1:0] i_rb_addr,
  output logic [DATA_W-1:0] o_a_data,
  output logic [DATA_W-1:0] o_b_data,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wa_addr,
  input  logic [DATA_W-1:0] i_wd,
  input  logic              i_flag_we,
  input  logic              i_zero_in,
  input  logic              i_cout_in,
  output logic              o_carry_q,
  output logic              o_zero_q
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_carry;
  logic              r_zero;

  logic w_wr_valid;
  logic w_byp_a;
  logic w_byp_b;

  // Bypass is gated by reset so both ports read 0 while held in reset.
  assign w_wr_valid = i_rst_n && i_we && (i_wa_addr != '0);
  assign w_byp_a    = w_wr_valid && (i_wa_addr == i_ra_addr);
  assign w_byp_b    = w_wr_valid && (i_wa_addr == i_rb_addr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_wa_addr != '0)) begin
      r_regs[i_wa_addr] <= i_wd;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
    end else if (i_flag_we) begin
      r_carry <= i_cout_in;
      r_zero  <= i_zero_in;
    end
  end

  always_comb begin
    o_a_data = '0;
    o_b_data = '0;
    if (i_ra_addr != '0) begin
      o_a_data = w_byp_a ? i_wd : r_regs[i_ra_addr];
    end
    if (i_rb_addr != '0) begin
      o_b_data = w_byp_b ? i_wd : r_regs[i_rb_addr];
    end
  end

  assign o_carry_q = r_carry;
  assign o_zero_q  = r_zero;

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_alu_regfile;

  logic       clk;
  logic       rst_n;
  logic [2:0] ra_addr;
  logic [2:0] rb_addr;
  logic [7:0] a_data;
  logic [7:0] b_data;
  logic       we;
  logic [2:0] wa_addr;
  logic [7:0] wd;
  logic       flag_we;
  logic       zero_in;
  logic       cout_in;
  logic       carry_q;
  logic       zero_q;

  bit clk_en;
  int n_tests;
  int n_fail;

  // Reference state
  logic [7:0] mdl_reg [8];
  logic       mdl_carry;
  logic       mdl_zero;

  alu_regfile #(
    .DATA_W(8),
    .NREG  (8),
    .ADDR_W(3)
  ) u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_ra_addr(ra_addr),
    .i_rb_addr(rb_addr),
    .o_a_data (a_data),
    .o_b_data (b_data),
    .i_we     (we),
    .i_wa_addr(wa_addr),
    .i_wd     (wd),
    .i_flag_we(flag_we),
    .i_zero_in(zero_in),
    .i_cout_in(cout_in),
    .o_carry_q(carry_q),
    .o_zero_q (zero_q)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [2:0] addr);
    if (addr == 3'd0) return 8'h00;
    if (!rst_n) return 8'h00;
    if (we && wa_addr != 3'd0 && wa_addr == addr) return wd;
    return mdl_reg[addr];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl_reg[i] = 8'h00;
    mdl_carry = 1'b0;
    mdl_zero  = 1'b0;
  endtask

  // Advance one rising edge, updating the model from the inputs held across it.
  task automatic cyc();
    if (rst_n) begin
      if (we && wa_addr != 3'd0) mdl_reg[wa_addr] = wd;
      if (flag_we) begin
        mdl_carry = cout_in;
        mdl_zero  = zero_in;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; wa_addr = a; wd = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic check_ports(input string tag);
    #1;
    check_eq({tag, "_a"}, a_data, exp_read(ra_addr));
    check_eq({tag, "_b"}, b_data, exp_read(rb_addr));
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    clk_en = 1'b0;
    rst_n = 1'b1;
    ra_addr = 3'd0; rb_addr = 3'd0;
    we = 1'b0; wa_addr = 3'd0; wd = 8'h00;
    flag_we = 1'b0; zero_in = 1'b0; cout_in = 1'b0;

    // Reset with no clock running.
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i); rb_addr = 3'(7 - i);
      #1;
      check_eq("rst_a", a_data, 8'h00);
      check_eq("rst_b", b_data, 8'h00);
    end
    check_eq("rst_carry", carry_q, 1'b0);
    check_eq("rst_zero", zero_q, 1'b0);

    #4 rst_n = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;

    // Write/read
    write_reg(3'd1, 8'hE5);
    write_reg(3'd2, 8'h06);
    ra_addr = 3'd1; rb_addr = 3'd2;
    #1;
    check_eq("wr_r1", a_data, 8'hE5);
    check_eq("wr_r2", b_data, 8'h06);

    // r0 protection: no bypass, no storage
    ra_addr = 3'd0; we = 1'b1; wa_addr = 3'd0; wd = 8'hFF;
    #1;
    check_eq("r0_byp", a_data, 8'h00);
    cyc();
    we = 1'b0;
    #1;
    check_eq("r0_store", a_data, 8'h00);

    // Bypass on both ports
    write_reg(3'd3, 8'h11);
    ra_addr = 3'd3; rb_addr = 3'd3;
    we = 1'b1; wa_addr = 3'd3; wd = 8'h7C;
    #1;
    check_eq("byp_a", a_data, 8'h7C);
    check_eq("byp_b", b_data, 8'h7C);
    cyc();
    we = 1'b0;
    #1;
    check_eq("byp_st_a", a_data, 8'h7C);
    check_eq("byp_st_b", b_data, 8'h7C);

    // Flag capture and hold
    flag_we = 1'b1; cout_in = 1'b1; zero_in = 1'b0;
    cyc();
    check_eq("flg_c1", carry_q, 1'b1);
    check_eq("flg_z0", zero_q, 1'b0);
    flag_we = 1'b0; cout_in = 1'b0; zero_in = 1'b1;
    cyc();
    check_eq("flg_hold_c", carry_q, 1'b1);
    check_eq("flg_hold_z", zero_q, 1'b0);
    flag_we = 1'b1; cout_in = 1'b1; zero_in = 1'b1;
    cyc();
    check_eq("flg_z1", zero_q, 1'b1);
    flag_we = 1'b0;

    // Reset mid-operation
    write_reg(3'd5, 8'hA3);
    flag_we = 1'b1; cout_in = 1'b1;
    cyc();
    flag_we = 1'b0;
    check_eq("mid_pre_c", carry_q, 1'b1);
    ra_addr = 3'd5; rb_addr = 3'd5;
    we = 1'b1; wa_addr = 3'd5; wd = 8'h3C;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_r5", a_data, 8'h00);
    check_eq("mid_c", carry_q, 1'b0);
    cyc();
    check_eq("mid_r5_clk", b_data, 8'h00);
    check_eq("mid_c_clk", carry_q, 1'b0);
    #2 rst_n = 1'b1;
    cyc();
    we = 1'b0;
    #1;
    check_eq("mid_rel_r5", a_data, 8'h3C);
    check_eq("mid_rel_r1", mdl_reg[1] == 8'h00 ? 32'(a_data) : 32'hDEAD, 8'h3C);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      we      = 1'($urandom);
      wa_addr = 3'($urandom);
      wd      = 8'($urandom);
      ra_addr = 3'($urandom);
      rb_addr = ($urandom_range(0, 3) == 0) ? wa_addr : 3'($urandom);
      flag_we = 1'($urandom);
      zero_in = 1'($urandom);
      cout_in = 1'($urandom);
      check_ports("rnd");
      cyc();
      check_eq("rnd_carry", carry_q, mdl_carry);
      check_eq("rnd_zero", zero_q, mdl_zero);
      // Flag inputs must not reach outputs combinationally.
      cout_in = ~cout_in; zero_in = ~zero_in;
      #1;
      check_eq("rnd_nocomb", {carry_q, zero_q}, {mdl_carry, mdl_zero});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
